// File: rtl/switch_led_controller.sv
// Debounces two active-low push-switches, turns presses into one-cycle events
// and drives two active-low LEDs from a three-mode (direct/toggle/blink) FSM.
module switch_led_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 270000,
  parameter int unsigned BLINK_HALF_CYCLES = 6750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch1,
  input  logic       switch2,
  output logic       led1,
  output logic       led2,
  output logic [1:0] mode,
  output logic       sw1_press,
  output logic       sw2_press
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned BL_W = $clog2(BLINK_HALF_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10
  } mode_e;

  // Index 0 is switch1, index 1 is switch2.
  logic [1:0]           sw_raw;
  logic [1:0]           sync1_q, sync2_q, stable_q, press_q;
  logic [1:0][DB_W-1:0] db_cnt_q;

  mode_e           mode_q, mode_d;
  logic            toggle_q, toggle_d;
  logic            blink_en_q, blink_en_d;
  logic            phase_q, phase_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            led1_d, led2_d;

  assign sw_raw = {switch2, switch1};

  // Two-flop synchroniser followed by a saturating-count debouncer per switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_MAX) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
          press_q[i]  <= ~sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next mode, per-mode datapath state and LED levels (LEDs follow next-state values).
  always_comb begin
    mode_d      = mode_q;
    toggle_d    = toggle_q;
    blink_en_d  = blink_en_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    led1_d      = 1'b1;
    led2_d      = 1'b1;

    case (mode_q)
      MODE_DIRECT: if (press_q[0]) mode_d = MODE_TOGGLE;
      MODE_TOGGLE: if (press_q[0]) mode_d = MODE_BLINK;
      MODE_BLINK:  if (press_q[0]) mode_d = MODE_DIRECT;
      default:     mode_d = MODE_DIRECT;
    endcase

    // A mode change swallows a coincident switch2 press.
    if (mode_d != mode_q) begin
      if (mode_d == MODE_TOGGLE) toggle_d = 1'b0;
      if (mode_d == MODE_BLINK) begin
        blink_en_d  = 1'b1;
        phase_d     = 1'b0;
        blink_cnt_d = '0;
      end
    end else if (mode_q == MODE_TOGGLE) begin
      if (press_q[1]) toggle_d = ~toggle_q;
    end else if (mode_q == MODE_BLINK) begin
      if (press_q[1]) begin
        blink_en_d  = ~blink_en_q;
        phase_d     = 1'b0;
        blink_cnt_d = '0;
      end else if (blink_en_q) begin
        if (blink_cnt_q == BL_MAX) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BL_W'(1);
        end
      end
    end

    case (mode_d)
      MODE_DIRECT: begin
        led1_d = stable_q[0];
        led2_d = stable_q[1];
      end
      MODE_TOGGLE: led2_d = ~toggle_d;
      MODE_BLINK: begin
        if (blink_en_d) begin
          led1_d = phase_d;
          led2_d = ~phase_d;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q    <= 1'b0;
      blink_en_q  <= 1'b0;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
      led1        <= 1'b1;
      led2        <= 1'b1;
    end else begin
      toggle_q    <= toggle_d;
      blink_en_q  <= blink_en_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      led1        <= led1_d;
      led2        <= led2_d;
    end
  end

  assign mode      = mode_q;
  assign sw1_press = press_q[0];
  assign sw2_press = press_q[1];

endmodule

// File: tb/tb_switch_led_controller.sv
// Directed bench for switch_led_controller with short debounce and blink periods.
module tb_switch_led_controller;

  logic       clk;
  logic       rst_n;
  logic       switch1;
  logic       switch2;
  logic       led1;
  logic       led2;
  logic [1:0] mode;
  logic       sw1_press;
  logic       sw2_press;

  int tests;
  int fails;
  int p1;
  int p2;

  switch_led_controller #(
    .DEBOUNCE_CYCLES  (4),
    .BLINK_HALF_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .switch1  (switch1),
    .switch2  (switch2),
    .led1     (led1),
    .led2     (led2),
    .mode     (mode),
    .sw1_press(sw1_press),
    .sw2_press(sw2_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit later and tally press pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sw1_press) p1++;
    if (sw2_press) p2++;
  endtask

  task automatic hold_sw1(input int lo, input int hi);
    switch1 = 1'b0;
    repeat (lo) tick();
    switch1 = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic hold_sw2(input int lo, input int hi);
    switch2 = 1'b0;
    repeat (lo) tick();
    switch2 = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; switch1 = 1'b1; switch2 = 1'b1;
    repeat (3) tick();
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL reset_led1 got %b want 1", led1); end
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL reset_led2 got %b want 1", led2); end
    tests++; if (mode !== 2'b00) begin fails++; $display("FAIL reset_mode got %b want 00", mode); end
    tests++; if (sw1_press !== 1'b0) begin fails++; $display("FAIL reset_sw1_press got %b want 0", sw1_press); end
    tests++; if (sw2_press !== 1'b0) begin fails++; $display("FAIL reset_sw2_press got %b want 0", sw2_press); end
    rst_n = 1'b1;
    p1 = 0; p2 = 0;
    switch2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 8) begin
        tests++;
        if (led2 !== ((k >= 7) ? 1'b0 : 1'b1)) begin
          fails++; $display("FAIL direct_led2_latency edge %0d got %b want %b", k, led2, (k >= 7) ? 1'b0 : 1'b1);
        end
        tests++;
        if (sw2_press !== ((k == 6) ? 1'b1 : 1'b0)) begin
          fails++; $display("FAIL sw2_press_timing edge %0d got %b want %b", k, sw2_press, (k == 6) ? 1'b1 : 1'b0);
        end
      end
    end
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL direct_led1_idle got %b want 1", led1); end
    tests++; if (mode !== 2'b00) begin fails++; $display("FAIL direct_mode got %b want 00", mode); end
    tests++; if (p2 !== 1) begin fails++; $display("FAIL sw2_press_count got %0d want 1", p2); end
    switch2 = 1'b1;
    repeat (12) tick();
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL direct_led2_release got %b want 1", led2); end
    tests++; if (p2 !== 1) begin fails++; $display("FAIL release_no_pulse got %0d want 1", p2); end
  endtask

  task automatic test_glitch();
    p1 = 0;
    hold_sw1(3, 10);
    tests++; if (p1 !== 0) begin fails++; $display("FAIL glitch_press got %0d want 0", p1); end
    tests++; if (mode !== 2'b00) begin fails++; $display("FAIL glitch_mode got %b want 00", mode); end
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL glitch_led1 got %b want 1", led1); end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [3];
    exp_mode[0] = 2'b01; exp_mode[1] = 2'b10; exp_mode[2] = 2'b00;
    p1 = 0;
    for (int n = 0; n < 3; n++) begin
      hold_sw1(10, 10);
      tests++;
      if (mode !== exp_mode[n]) begin fails++; $display("FAIL mode_cycle_%0d got %b want %b", n, mode, exp_mode[n]); end
      tests++;
      if (p1 !== n + 1) begin fails++; $display("FAIL mode_cycle_pulses_%0d got %0d want %0d", n, p1, n + 1); end
    end
  endtask

  task automatic test_toggle();
    hold_sw1(10, 10);
    tests++; if (mode !== 2'b01) begin fails++; $display("FAIL toggle_mode got %b want 01", mode); end
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL toggle_entry_led2 got %b want 1", led2); end
    hold_sw2(10, 10);
    tests++; if (led2 !== 1'b0) begin fails++; $display("FAIL toggle_first_led2 got %b want 0", led2); end
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL toggle_first_led1 got %b want 1", led1); end
    hold_sw2(10, 10);
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL toggle_second_led2 got %b want 1", led2); end
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL toggle_second_led1 got %b want 1", led1); end
    tests++; if (mode !== 2'b01) begin fails++; $display("FAIL toggle_mode_kept got %b want 01", mode); end
  endtask

  task automatic test_blink();
    logic ph;
    switch1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 10) switch1 = 1'b1;
      if (k == 7) begin
        tests++; if (mode !== 2'b10) begin fails++; $display("FAIL blink_mode got %b want 10", mode); end
      end
      if (k >= 7) begin
        ph = (((k - 7) / 8) % 2) == 1;
        tests++;
        if (led1 !== ph) begin fails++; $display("FAIL blink_led1 edge %0d got %b want %b", k, led1, ph); end
        tests++;
        if (led2 !== ~ph) begin fails++; $display("FAIL blink_led2 edge %0d got %b want %b", k, led2, ~ph); end
      end
    end
    hold_sw2(10, 10);
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL blink_off_led1 got %b want 1", led1); end
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL blink_off_led2 got %b want 1", led2); end
    tests++; if (mode !== 2'b10) begin fails++; $display("FAIL blink_off_mode got %b want 10", mode); end
    switch2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) switch2 = 1'b1;
      ph = (k >= 7) && ((((k - 7) / 8) % 2) == 1);
      tests++;
      if (led1 !== ((k < 7) ? 1'b1 : ph)) begin
        fails++; $display("FAIL blink_restart_led1 edge %0d got %b want %b", k, led1, (k < 7) ? 1'b1 : ph);
      end
      tests++;
      if (led2 !== ((k < 7) ? 1'b1 : ~ph)) begin
        fails++; $display("FAIL blink_restart_led2 edge %0d got %b want %b", k, led2, (k < 7) ? 1'b1 : ~ph);
      end
    end
  endtask

  task automatic test_simultaneous_and_reset();
    hold_sw1(10, 10);
    hold_sw1(10, 10);
    tests++; if (mode !== 2'b01) begin fails++; $display("FAIL simul_setup_mode got %b want 01", mode); end
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL simul_setup_led2 got %b want 1", led2); end
    switch1 = 1'b0; switch2 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 10) begin switch1 = 1'b1; switch2 = 1'b1; end
      if (k == 6) begin
        tests++; if (sw1_press !== 1'b1) begin fails++; $display("FAIL simul_sw1_press got %b want 1", sw1_press); end
        tests++; if (sw2_press !== 1'b1) begin fails++; $display("FAIL simul_sw2_press got %b want 1", sw2_press); end
      end
      if (k == 7) begin
        tests++; if (mode !== 2'b10) begin fails++; $display("FAIL simul_mode got %b want 10", mode); end
        tests++; if (led1 !== 1'b0) begin fails++; $display("FAIL simul_led1 got %b want 0", led1); end
        tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL simul_led2 got %b want 1", led2); end
      end
      if (k == 15) begin
        tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL simul_phase1_led1 got %b want 1", led1); end
        tests++; if (led2 !== 1'b0) begin fails++; $display("FAIL simul_phase1_led2 got %b want 0", led2); end
      end
    end
    switch1 = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (led1 !== 1'b1) begin fails++; $display("FAIL midreset_led1 got %b want 1", led1); end
    tests++; if (led2 !== 1'b1) begin fails++; $display("FAIL midreset_led2 got %b want 1", led2); end
    tests++; if (mode !== 2'b00) begin fails++; $display("FAIL midreset_mode got %b want 00", mode); end
    tests++; if (sw1_press !== 1'b0) begin fails++; $display("FAIL midreset_sw1_press got %b want 0", sw1_press); end
    tests++; if (sw2_press !== 1'b0) begin fails++; $display("FAIL midreset_sw2_press got %b want 0", sw2_press); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 6) begin
        tests++;
        if (sw1_press !== ((k == 6) ? 1'b1 : 1'b0)) begin
          fails++; $display("FAIL post_reset_press edge %0d got %b want %b", k, sw1_press, (k == 6) ? 1'b1 : 1'b0);
        end
      end
      if (k == 7) begin
        tests++; if (mode !== 2'b01) begin fails++; $display("FAIL post_reset_mode got %b want 01", mode); end
      end
    end
    switch1 = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    tests = 0; fails = 0; p1 = 0; p2 = 0;
    rst_n = 1'b0; switch1 = 1'b1; switch2 = 1'b1;
    test_reset();
    test_glitch();
    test_mode_cycle();
    test_toggle();
    test_blink();
    test_simultaneous_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_led_controller.md
# switch_led_controller

Sequences the board's two active-low push-switches and two active-low LEDs. It synchronises and debounces both switches, turns each clean press into a one-cycle event, and runs a three-mode LED state machine selected by switch1. This replaces the direct switch-to-LED wiring with a registered controller at the top level; it runs on the 27 MHz board clock.

## Interface

- DEBOUNCE_CYCLES, 270000: consecutive cycles a synchronised input must differ from its debounced state before that state updates (10 ms at 27 MHz); minimum 2.
- BLINK_HALF_CYCLES, 6750000: cycles per blink phase (250 ms at 27 MHz); minimum 2.
- clk  input  1  board clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- switch1  input  1  raw switch, active-low (0 = pressed); asynchronous to clk.
- switch2  input  1  raw switch, active-low (0 = pressed); asynchronous to clk.
- led1  output  1  registered, active-low (0 = lit).
- led2  output  1  registered, active-low (0 = lit).
- mode  output  2  current mode: 00 DIRECT, 01 TOGGLE, 10 BLINK.
- sw1_press  output  1  one-cycle pulse on each debounced switch1 press.
- sw2_press  output  1  one-cycle pulse on each debounced switch2 press.

## Operation

- **Synchroniser:** two flops per switch, reset to 1.
- **Debouncer (per switch):**
  - Keeps a stable bit (reset 1) and a counter sized $clog2(DEBOUNCE_CYCLES) (reset 0).
  - While sync equals stable, the counter clears to 0.
  - While sync differs from stable, the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 and sync still differs, stable takes sync and the counter clears.
- **Press pulse:** swN_press is registered and goes high on the same edge that stable goes 1->0, for exactly one cycle. A release produces no pulse.
- **Mode FSM:** sw1_press advances DIRECT -> TOGGLE -> BLINK -> DIRECT. Encoding 11 is unreachable; if it is ever present, the next state is DIRECT.
- **DIRECT:** led1 lit iff switch1 stable is 0; led2 lit iff switch2 stable is 0.
- **TOGGLE:**
  - led1 off; led2 lit iff toggle_q = 1.
  - sw2_press inverts toggle_q.
  - Entering TOGGLE clears toggle_q to 0.
- **BLINK:**
  - The blink counter runs 0..BLINK_HALF_CYCLES-1 and toggles phase on wrap.
  - phase 0: led1 lit, led2 off. phase 1: led1 off, led2 lit.
  - sw2_press inverts blink_en. While blink_en = 0, both LEDs are off, the counter is held at 0 and phase at 0.
  - Entering BLINK sets blink_en = 1, counter = 0, phase = 0.
- **Simultaneous sw1_press and sw2_press in the same cycle:** the mode change is taken and sw2_press is ignored.
- **Outside their modes:** toggle_q and blink state are held, not cleared, except by the entry rules above.

## Timing

- **Reset values (async on rst_n low):**
  - Registered outputs: led1 = 1, led2 = 1 (both off), mode = 00, sw1_press = 0, sw2_press = 0.
  - Internal state: toggle_q = 0, blink_en = 0, phase = 0, all counters 0.
- **Pin change to stable:** stable changes on edge 2 + DEBOUNCE_CYCLES after the first edge that samples the new pin level, provided the level is held throughout.
- **Press pulse:** swN_press is high in the cycle stable falls.
- **Stable/press to outputs:** mode, led1, led2, toggle_q and blink_en update one edge after stable changes or swN_press is seen. DIRECT-mode pin-to-LED latency is therefore DEBOUNCE_CYCLES + 3 edges.
- **Glitch rejection:** a pin pulse shorter than DEBOUNCE_CYCLES synchronised cycles clears the counter and produces no stable change and no pulse.
- **Blink:** phase flips every BLINK_HALF_CYCLES cycles. The first flip occurs BLINK_HALF_CYCLES cycles after the edge on which mode becomes 10.
- **Reset mid-debounce or mid-blink:** all state returns to reset values immediately. After rst_n rises, a switch still held low needs a full 2 + DEBOUNCE_CYCLES edges, then produces a press pulse.

## Test plan

Bench parameters: DEBOUNCE_CYCLES = 4, BLINK_HALF_CYCLES = 8.

1. **Reset:** assert rst_n = 0 with switches = 1 -> led1 = led2 = 1, mode = 00, pulses 0. Then release reset and press switch2 for 20 cycles -> led2 = 0 exactly 7 edges after the first sampling edge, led1 stays 1, one sw2_press pulse, mode stays 00.
2. **Glitch rejection:** drive switch1 low for 3 cycles, then high -> no sw1_press, mode stays 00, led1 stays 1.
3. **Mode cycling:** give three clean switch1 presses, each held 10 cycles with 10-cycle gaps -> mode goes 01, 10, 00, with exactly one sw1_press per press.
4. **TOGGLE:** in mode 01, press switch2 twice -> led2 goes 0 after the first press and 1 after the second; led1 stays 1 throughout.
5. **BLINK:**
   - Enter mode 10 -> led1 = 0, led2 = 1 for 8 cycles, then swap, repeating.
   - Press switch2 -> both LEDs 1.
   - Press switch2 again -> restarts at phase 0.
6. **Simultaneous press and mid-operation reset:**
   - Align both presses so sw1_press and sw2_press pulse in the same cycle while in mode 01 with toggle_q = 0 -> mode becomes 10 and led2 follows the BLINK phase pattern, not the toggle.
   - Then assert rst_n mid-blink -> all outputs return to reset values within the same time step.
